// File: rtl/v2f_ram_pkg.sv
// v2f_ram_pkg: shared FSM state encoding and default RAM geometry for the v2f RAM arbiter
package v2f_ram_pkg;
  localparam int ABITS_DEF = 3;
  localparam int DBITS_DEF = 32;
  localparam int SIZE_DEF = 8;
  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/v2f_rr_arb2.sv
// v2f_rr_arb2: two-way round-robin arbiter; ports clk, arst_n, en (arbitration allowed), req[1:0] (A=0,B=1), gnt[1:0] one-hot combinational grant
module v2f_rr_arb2 (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_b;
  always_comb gnt = !en ? 2'b00 : (&req) ? (last_b ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) last_b <= 1'b1;
    else if (|gnt) last_b <= gnt[1];
endmodule

// File: rtl/v2f_ram_arbiter.sv
// v2f_ram_arbiter: arbitrates requesters A/B onto an external async-read RAM with a clear sweep; ports clk, arst_n, a_*/b_* request/grant/rvalid, rdata, clr/busy/clr_done, ram_* RAM interface
module v2f_ram_arbiter
  import v2f_ram_pkg::*;
#(
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int SIZE = SIZE_DEF
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               a_req,
  input  logic               b_req,
  input  logic               a_we,
  input  logic               b_we,
  input  logic [ABITS-1:0]   a_addr,
  input  logic [ABITS-1:0]   b_addr,
  input  logic [DBITS-1:0]   a_wdata,
  input  logic [DBITS-1:0]   b_wdata,
  input  logic [DBITS/8-1:0] a_be,
  input  logic [DBITS/8-1:0] b_be,
  output logic               a_gnt,
  output logic               b_gnt,
  output logic               a_rvalid,
  output logic               b_rvalid,
  output logic [DBITS-1:0]   rdata,
  input  logic               clr,
  output logic               busy,
  output logic               clr_done,
  output logic [ABITS-1:0]   ram_rd_addr,
  input  logic [DBITS-1:0]   ram_rd_data,
  output logic               ram_wr_en,
  output logic [ABITS-1:0]   ram_wr_addr,
  output logic [DBITS-1:0]   ram_wr_data,
  output logic [DBITS/8-1:0] ram_byte_select
);
  localparam logic [ABITS-1:0] LAST = ABITS'(SIZE - 1);
  state_t state, state_nx;
  logic [ABITS-1:0] cnt;
  logic [1:0] gnt;
  logic clear, last, en, win_b, rd, w_we;
  logic [ABITS-1:0] w_addr;
  logic [DBITS-1:0] w_wdata;
  logic [DBITS/8-1:0] w_be;
  assign clear = state == CLEAR;
  assign last = cnt == LAST;
  // reset is folded in so no grant (and hence no RAM write) leaks out while held in reset
  assign en = arst_n & !clear & !clr;
  v2f_rr_arb2 u_arb (.clk(clk), .arst_n(arst_n), .en(en), .req({b_req, a_req}), .gnt(gnt));
  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign win_b = gnt[1];
  assign w_we = win_b ? b_we : a_we;
  assign w_addr = win_b ? b_addr : a_addr;
  assign w_wdata = win_b ? b_wdata : a_wdata;
  assign w_be = win_b ? b_be : a_be;
  assign rd = |gnt & !w_we;
  assign ram_rd_addr = w_addr;
  assign ram_wr_en = clear | (|gnt & w_we);
  assign ram_wr_addr = clear ? cnt : w_addr;
  assign ram_wr_data = clear ? '0 : w_wdata;
  assign ram_byte_select = clear ? '1 : w_be;
  assign busy = clear;
  assign clr_done = clear & last;
  always_comb state_nx = clear ? (last ? SERVE : CLEAR) : (clr ? CLEAR : SERVE);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= SERVE;
      cnt <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= clear & !last ? cnt + 1'b1 : '0;
      a_rvalid <= rd & !win_b;
      b_rvalid <= rd & win_b;
      if (rd) rdata <= ram_rd_data;
    end
endmodule

// File: tb/tb_v2f_ram_arbiter.sv
// tb_v2f_ram_arbiter: randomized + directed scoreboard bench for v2f_ram_arbiter with an external RAM model
module tb_v2f_ram_arbiter;
  localparam int AB = 3;
  localparam int DB = 32;
  localparam int SZ = 8;
  localparam int NB = DB / 8;
  typedef struct {
    bit we;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic [NB-1:0] be;
  } txn_t;
  typedef struct {
    int due;
    logic [DB-1:0] data;
  } exp_t;
  logic clk = 0, arst_n = 1, clr = 0;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [AB-1:0] a_addr = '0, b_addr = '0;
  logic [DB-1:0] a_wdata = '0, b_wdata = '0;
  logic [NB-1:0] a_be = '0, b_be = '0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, busy, clr_done, ram_wr_en;
  logic [DB-1:0] rdata, ram_rd_data, ram_wr_data;
  logic [AB-1:0] ram_rd_addr, ram_wr_addr;
  logic [NB-1:0] ram_byte_select;
  logic [DB-1:0] ram [SZ];
  logic [DB-1:0] mem [SZ];
  txn_t qa[$], qb[$];
  exp_t ea[$], eb[$];
  int clear_left = 0, cyc = 0, tests = 0, errors = 0;
  bit last_b = 1;

  v2f_ram_arbiter #(.ABITS(AB), .DBITS(DB), .SIZE(SZ)) dut (
    .clk(clk), .arst_n(arst_n),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_be(a_be), .b_be(b_be), .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata),
    .clr(clr), .busy(busy), .clr_done(clr_done),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_byte_select(ram_byte_select)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (ram_wr_en)
      for (int i = 0; i < NB; i++)
        if (ram_byte_select[i]) ram[ram_wr_addr][i*8 +: 8] <= ram_wr_data[i*8 +: 8];
  assign ram_rd_data = ram[ram_rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic txn_t mk(input bit we, input int addr, input logic [DB-1:0] d, input logic [NB-1:0] be);
    txn_t t;
    t.we = we;
    t.addr = AB'(addr);
    t.wdata = d;
    t.be = be;
    return t;
  endfunction

  function automatic txn_t rnd();
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, SZ - 1)), $urandom, NB'($urandom_range(0, 15)));
  endfunction

  // Reference: round-robin by "who was served last", byte-lane merge into a word array, clear as a countdown
  task automatic model_check();
    bit ga = 0, gb = 0, ew = 0;
    logic [AB-1:0] ewa = '0;
    logic [DB-1:0] ewd = '0;
    logic [NB-1:0] ebe = '0;
    txn_t t;
    if (clear_left > 0) begin
      ew = 1;
      ewa = AB'(SZ - clear_left);
      ebe = '1;
    end else if (!clr) begin
      if (a_req && b_req) begin
        ga = last_b;
        gb = !last_b;
      end else begin
        ga = a_req;
        gb = b_req;
      end
    end
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("busy", busy, clear_left > 0);
    chk("clr_done", clr_done, clear_left == 1);
    if (ga || gb) begin
      if (ga) t = qa.pop_front();
      else t = qb.pop_front();
      last_b = gb;
      if (t.we) begin
        ew = 1;
        ewa = t.addr;
        ewd = t.wdata;
        ebe = t.be;
        for (int i = 0; i < NB; i++) if (t.be[i]) mem[t.addr][i*8 +: 8] = t.wdata[i*8 +: 8];
      end else begin
        chk("ram_rd_addr", ram_rd_addr, t.addr);
        if (ga) ea.push_back(exp_t'{due: cyc + 1, data: mem[t.addr]});
        else eb.push_back(exp_t'{due: cyc + 1, data: mem[t.addr]});
      end
    end
    chk("ram_wr_en", ram_wr_en, ew);
    if (ew) begin
      chk("ram_wr_addr", ram_wr_addr, ewa);
      chk("ram_wr_data", ram_wr_data, ewd);
      chk("ram_byte_select", ram_byte_select, ebe);
    end
    if (clear_left > 0) begin
      mem[SZ - clear_left] = '0;
      clear_left--;
    end else if (clr) clear_left = SZ;
  endtask

  task automatic step(input bit c);
    @(posedge clk);
    #1;
    clr = c;
    a_req = qa.size() > 0;
    if (a_req) begin
      a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; a_be = qa[0].be;
    end
    b_req = qb.size() > 0;
    if (b_req) begin
      b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; b_be = qb[0].be;
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (qa.size() > 0 || qb.size() > 0); i++) step(0);
    if (qa.size() > 0 || qb.size() > 0) flag("drain timeout: requests never granted");
    step(0);
    step(0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    a_req = 1;
    a_we = 1;
    clr = 0;
    arst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_a_gnt", a_gnt, 0);
    a_req = 0;
    b_req = 0;
    clear_left = 0;
    last_b = 1;
    qa.delete(); qb.delete(); ea.delete(); eb.delete();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
  endtask

  always @(negedge clk)
    if (arst_n) begin
      if (a_rvalid && b_rvalid) flag("both rvalid high in one cycle");
      if (a_rvalid === 1'b1) begin
        if (ea.size() > 0 && ea[0].due == cyc) begin
          chk("a_rdata", rdata, ea[0].data);
          void'(ea.pop_front());
        end else flag("a_rvalid unexpected");
      end else if (ea.size() > 0 && ea[0].due <= cyc) begin
        flag("a_rvalid missing");
        void'(ea.pop_front());
      end
      if (b_rvalid === 1'b1) begin
        if (eb.size() > 0 && eb[0].due == cyc) begin
          chk("b_rdata", rdata, eb[0].data);
          void'(eb.pop_front());
        end else flag("b_rvalid unexpected");
      end else if (eb.size() > 0 && eb[0].due <= cyc) begin
        flag("b_rvalid missing");
        void'(eb.pop_front());
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = '0;
    do_reset();
    qa.push_back(mk(0, 0, 0, 0));
    step(1);
    repeat (SZ) step(0);
    for (int i = 0; i < SZ; i++) qa.push_back(mk(0, i, 0, 0));
    drain();
    qa.push_back(mk(1, 5, 32'hDEADBEEF, 4'hF));
    qa.push_back(mk(0, 5, 0, 0));
    drain();
    qa.push_back(mk(1, 2, 32'h11223344, 4'hF));
    drain();
    qb.push_back(mk(1, 2, 32'hAABBCCDD, 4'b0101));
    drain();
    qa.push_back(mk(0, 2, 0, 0));
    drain();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(0, i, 0, 0));
      qb.push_back(mk(0, i + 4, 0, 0));
    end
    drain();
    qa.push_back(mk(1, 6, 32'hCAFEF00D, 4'hF));
    step(0);
    qb.push_back(mk(0, 6, 0, 0));
    drain();
    repeat (400) begin
      if (qa.size() < 2 && $urandom_range(0, 2) != 0) qa.push_back(rnd());
      if (qb.size() < 2 && $urandom_range(0, 2) != 0) qb.push_back(rnd());
      step($urandom_range(0, 39) == 0);
    end
    drain();
    qa.push_back(mk(1, 3, 32'h5A5A5A5A, 4'hF));
    qa.push_back(mk(1, 2, 32'h12345678, 4'hF));
    drain();
    step(1);
    repeat (3) step(0);
    do_reset();
    qa.push_back(mk(0, 3, 0, 0));
    qa.push_back(mk(0, 2, 0, 0));
    drain();
    chk("leftover expected reads", ea.size() + eb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
